// File: rtl/lcd_text_refresh_if.sv
// lcd_text_refresh_if: frame request, character memory and HD44780 bus signals between the refresher and its host.
// master: the refresher. Drives mem_addr, busy, frame_done and LCD_*; receives start, continuous and mem_data.
// slave: the host. Drives start, continuous and mem_data; observes everything else.
interface lcd_text_refresh_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              continuous;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              busy;
    logic              frame_done;
    logic [7:0]        LCD_DATA;
    logic              LCD_RW;
    logic              LCD_EN;
    logic              LCD_RS;
    logic              LCD_ON;
    modport master (
        input  start, continuous, mem_data,
        output mem_addr, busy, frame_done, LCD_DATA, LCD_RW, LCD_EN, LCD_RS, LCD_ON
    );
    modport slave (
        output start, continuous, mem_data,
        input  mem_addr, busy, frame_done, LCD_DATA, LCD_RW, LCD_EN, LCD_RS, LCD_ON
    );
endinterface

// File: rtl/lcd_text_refresh.sv
// lcd_text_refresh: HD44780 power-on init plus one-shot or continuous refresh of a ROWS x COLS text window.
// clk, rst: clock and synchronous active-high reset.
// bus (master): start/continuous requests, busy/frame_done status, synchronous character memory port
// (mem_data valid one cycle after mem_addr), and the registered LCD bus LCD_DATA/RW/EN/RS/ON.
module lcd_text_refresh #(
    parameter int COLS      = 16,
    parameter int ROWS      = 2,
    parameter int ADDR_W    = 6,
    parameter int POR_DLY   = 800000,
    parameter int SETUP_CYC = 4,
    parameter int EN_CYC    = 24,
    parameter int CMD_DLY   = 2500,
    parameter int CLR_DLY   = 100000
) (
    input logic                clk,
    input logic                rst,
    lcd_text_refresh_if.master bus
);
    localparam int MAX_DLY = POR_DLY > CLR_DLY ? POR_DLY : CLR_DLY;
    localparam int CW = $clog2(MAX_DLY + 1);
    localparam logic [7:0] FUNC = ROWS > 1 ? 8'h38 : 8'h30;
    typedef enum logic [2:0] {POR, INIT, IDLE, ROWCMD, FETCH, CHAR, FEND} state_t;
    typedef enum logic [1:0] {SU, ENH, DL} phase_t;
    state_t st;
    phase_t ph;
    logic [CW-1:0] cnt;
    logic [1:0] ii, r;
    logic [5:0] c;
    logic [ADDR_W-1:0] addr;
    logic f, pend, is_clr, wr_done, last_col, ev_idle, ev_frame, ev_fetch, ev_row, ev_fend;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        return i == 2'd0 ? FUNC : i == 2'd1 ? 8'h0C : i == 2'd2 ? 8'h01 : 8'h06;
    endfunction

    function automatic logic [7:0] row_cmd(input logic [1:0] i);
        return i == 2'd0 ? 8'h80 : i == 2'd1 ? 8'hC0 : i == 2'd2 ? 8'h94 : 8'hD4;
    endfunction

    assign bus.LCD_RW = 1'b0;

    // Phase-end events; the sequencer below applies them in priority order.
    always_comb begin
        is_clr   = !bus.LCD_RS && (bus.LCD_DATA == 8'h01 || bus.LCD_DATA == 8'h02);
        wr_done  = ph == DL && cnt == (is_clr ? CW'(CLR_DLY - 1) : CW'(CMD_DLY - 1));
        last_col = st == CHAR && wr_done && c == 6'(COLS - 1);
        ev_idle  = (st == INIT && wr_done && ii == 2'd3) || st == FEND;
        // Leaving init or a frame consumes a pending/same-cycle start directly, skipping IDLE.
        ev_frame = (st == IDLE && (bus.start || bus.continuous)) ||
                   (ev_idle && (pend || bus.start || (st == FEND && bus.continuous)));
        ev_fetch = (st == ROWCMD && wr_done) || (st == CHAR && wr_done && !last_col);
        ev_row   = last_col && r != 2'(ROWS - 1);
        ev_fend  = last_col && r == 2'(ROWS - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st             <= POR;
            ph             <= SU;
            cnt            <= '0;
            ii             <= '0;
            r              <= '0;
            c              <= '0;
            addr           <= '0;
            f              <= 1'b0;
            pend           <= 1'b0;
            bus.mem_addr   <= '0;
            bus.busy       <= 1'b1;
            bus.frame_done <= 1'b0;
            bus.LCD_DATA   <= '0;
            bus.LCD_EN     <= 1'b0;
            bus.LCD_RS     <= 1'b0;
            bus.LCD_ON     <= 1'b0;
        end else begin
            bus.LCD_ON     <= 1'b1;
            bus.frame_done <= 1'b0;
            if (bus.start && st != IDLE) pend <= 1'b1;
            if (ev_frame) begin
                st           <= ROWCMD;
                r            <= '0;
                c            <= '0;
                addr         <= '0;
                pend         <= 1'b0;
                bus.busy     <= 1'b1;
                bus.LCD_DATA <= 8'h80;
                bus.LCD_RS   <= 1'b0;
                ph           <= SU;
                cnt          <= '0;
            end else if (ev_idle) begin
                st       <= IDLE;
                bus.busy <= 1'b0;
            end else if (ev_fend) begin
                st             <= FEND;
                bus.frame_done <= 1'b1;
            end else if (ev_row) begin
                st           <= ROWCMD;
                r            <= r + 2'd1;
                c            <= '0;
                bus.LCD_DATA <= row_cmd(r + 2'd1);
                bus.LCD_RS   <= 1'b0;
                ph           <= SU;
                cnt          <= '0;
            end else if (ev_fetch) begin
                st           <= FETCH;
                f            <= 1'b0;
                bus.mem_addr <= addr;
                addr         <= addr + 1'b1;
                if (st == CHAR) c <= c + 1'b1;
            end else begin
                case (st)
                    POR:
                        if (cnt == CW'(POR_DLY - 1)) begin
                            st           <= INIT;
                            ii           <= '0;
                            bus.LCD_DATA <= FUNC;
                            ph           <= SU;
                            cnt          <= '0;
                        end else cnt <= cnt + 1'b1;
                    // Second fetch cycle: memory has had one edge to answer the address.
                    FETCH:
                        if (f) begin
                            st           <= CHAR;
                            bus.LCD_DATA <= bus.mem_data;
                            bus.LCD_RS   <= 1'b1;
                            ph           <= SU;
                            cnt          <= '0;
                        end else f <= 1'b1;
                    INIT, ROWCMD, CHAR:
                        if (ph == SU && cnt == CW'(SETUP_CYC - 1)) begin
                            ph         <= ENH;
                            bus.LCD_EN <= 1'b1;
                            cnt        <= '0;
                        end else if (ph == ENH && cnt == CW'(EN_CYC - 1)) begin
                            ph         <= DL;
                            bus.LCD_EN <= 1'b0;
                            cnt        <= '0;
                        end else if (wr_done) begin
                            ii           <= ii + 2'd1;
                            bus.LCD_DATA <= init_cmd(ii + 2'd1);
                            ph           <= SU;
                            cnt          <= '0;
                        end else cnt <= cnt + 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lcd_text_refresh.sv
// tb_lcd_text_refresh: directed checks of init timing, frame contents, request handling and reset abort.
module tb_lcd_text_refresh;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst4 = 1'b1;
    always #5 clk = ~clk;

    lcd_text_refresh_if #(.ADDR_W(6)) b ();
    lcd_text_refresh_if #(.ADDR_W(7)) b4 ();

    lcd_text_refresh #(
        .COLS(4), .ROWS(2), .ADDR_W(6), .POR_DLY(10), .SETUP_CYC(2), .EN_CYC(4), .CMD_DLY(8), .CLR_DLY(32)
    ) dut (.clk(clk), .rst(rst), .bus(b.master));

    lcd_text_refresh #(
        .COLS(20), .ROWS(4), .ADDR_W(7), .POR_DLY(3), .SETUP_CYC(1), .EN_CYC(1), .CMD_DLY(1), .CLR_DLY(2)
    ) dut4 (.clk(clk), .rst(rst4), .bus(b4.master));

    logic [7:0] mem [0:63];
    always @(posedge clk) b.mem_data <= mem[b.mem_addr];
    always @(posedge clk) b4.mem_data <= {1'b0, b4.mem_addr};

    int n_chk = 0;
    int n_err = 0;
    int bad_en = 0;
    int run = 0;
    logic en_q = 1'b0;
    logic en4_q = 1'b0;
    logic [8:0] qd[$];
    logic [5:0] qa[$];
    logic [7:0] cq4[$];

    // Capture every write at its EN rise; also flag any EN pulse not exactly 4 cycles wide.
    always @(negedge clk) begin
        if (rst) begin
            en_q <= 1'b0;
            run  <= 0;
        end else begin
            if (b.LCD_EN && !en_q) begin
                qd.push_back({b.LCD_RS, b.LCD_DATA});
                qa.push_back(b.mem_addr);
            end
            if (!b.LCD_EN && en_q && run != 4) bad_en <= bad_en + 1;
            run  <= b.LCD_EN ? run + 1 : 0;
            en_q <= b.LCD_EN;
        end
    end

    always @(negedge clk) begin
        if (rst4) en4_q <= 1'b0;
        else begin
            if (b4.LCD_EN && !en4_q && !b4.LCD_RS) cq4.push_back(b4.LCD_DATA);
            en4_q <= b4.LCD_EN;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: holds reset over one edge, checks reset values, releases.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", b.busy, 1);
        chk("rst_en", b.LCD_EN, 0);
        chk("rst_on", b.LCD_ON, 0);
        chk("rst_data", b.LCD_DATA, 0);
        chk("rst_rs", b.LCD_RS, 0);
        chk("rst_rw", b.LCD_RW, 0);
        chk("rst_addr", b.mem_addr, 0);
        chk("rst_done", b.frame_done, 0);
        rst = 1'b0;
        qd.delete();
        qa.delete();
    endtask

    // Samples after each edge t following reset release: POR 10, writes 14/14/38/14, idle at 90.
    task automatic init_timeline();
        for (int t = 1; t <= 90; t++) begin
            @(negedge clk);
            if (t == 1) chk("on_c1", b.LCD_ON, 1);
            if (t == 9) chk("por_data", b.LCD_DATA, 8'h00);
            if (t == 10) chk("func_data", {b.LCD_RS, b.LCD_DATA}, 9'h038);
            if (t == 11) chk("func_setup", b.LCD_EN, 0);
            if (t == 12) chk("func_en_rise", b.LCD_EN, 1);
            if (t == 15) chk("func_en_hold", b.LCD_EN, 1);
            if (t == 16) chk("func_en_fall", b.LCD_EN, 0);
            if (t == 23) chk("func_settle", b.LCD_DATA, 8'h38);
            if (t == 24) chk("disp_data", b.LCD_DATA, 8'h0C);
            if (t == 38) chk("clr_data", b.LCD_DATA, 8'h01);
            if (t == 75) chk("clr_settle", b.LCD_DATA, 8'h01);
            if (t == 76) chk("entry_data", b.LCD_DATA, 8'h06);
            if (t == 89) chk("busy_89", b.busy, 1);
            if (t == 90) chk("busy_90", b.busy, 0);
        end
    endtask

    task automatic check_init_seq(input string tag);
        chk({tag, "_0"}, qd[0], 9'h038);
        chk({tag, "_1"}, qd[1], 9'h00C);
        chk({tag, "_2"}, qd[2], 9'h001);
        chk({tag, "_3"}, qd[3], 9'h006);
    endtask

    task automatic check_frame(input int base, input string tag);
        int k = base;
        for (int r = 0; r < 2; r++) begin
            chk({tag, "_row"}, qd[k], r == 0 ? 9'h080 : 9'h0C0);
            k++;
            for (int c = 0; c < 4; c++) begin
                chk({tag, "_chr"}, qd[k], {1'b1, mem[r * 4 + c]});
                chk({tag, "_adr"}, qa[k], r * 4 + c);
                k++;
            end
        end
    endtask

    task automatic run_idle(input int max, output int nd);
        nd = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (b.frame_done) nd++;
            if (!b.busy) break;
        end
        chk("idle_reached", b.busy, 0);
    endtask

    task automatic pulse_start();
        b.start = 1'b1;
        @(negedge clk);
        b.start = 1'b0;
    endtask

    initial begin
        int nd;
        int drop_at;
        logic hit;
        logic [7:0] e4 [8] = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80, 8'hC0, 8'h94, 8'hD4};
        b.start = 1'b0;
        b.continuous = 1'b0;
        b4.start = 1'b0;
        b4.continuous = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h41 + 8'(i);
        @(negedge clk);
        do_reset();
        init_timeline();
        chk("init_count", qd.size(), 4);
        check_init_seq("init");

        // single frame from IDLE
        qd.delete();
        qa.delete();
        pulse_start();
        run_idle(400, nd);
        chk("f1_done_cnt", nd, 1);
        chk("f1_len", qd.size(), 10);
        check_frame(0, "f1");

        // start during init plus three starts during frame 1: exactly two back-to-back frames
        do_reset();
        repeat (20) @(negedge clk);
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            hit = qd.size() >= 5;
        end
        chk("f2a_started", hit, 1);
        for (int k = 0; k < 3; k++) begin
            repeat (10) @(negedge clk);
            pulse_start();
        end
        run_idle(1000, nd);
        chk("pend_done_cnt", nd, 2);
        chk("pend_len", qd.size(), 24);
        check_init_seq("pinit");
        check_frame(4, "p1");
        check_frame(14, "p2");
        repeat (20) @(negedge clk);
        chk("pend_no_third", b.busy, 0);

        // continuous for three frames, dropped mid-frame 3
        qd.delete();
        qa.delete();
        b.continuous = 1'b1;
        nd = 0;
        drop_at = -1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (b.frame_done) nd++;
            if (nd == 2 && drop_at < 0) drop_at = i + 30;
            if (i == drop_at) b.continuous = 1'b0;
            if (!b.busy) break;
        end
        chk("cont_idle", b.busy, 0);
        chk("cont_done_cnt", nd, 3);
        chk("cont_len", qd.size(), 30);
        check_frame(0, "c1");
        check_frame(10, "c2");
        check_frame(20, "c3");

        // memory change between frames appears at the sixth character
        mem[5] = 8'h5A;
        qd.delete();
        qa.delete();
        pulse_start();
        run_idle(400, nd);
        chk("m_done_cnt", nd, 1);
        chk("m_char4", qd[6], 9'h145);
        chk("m_char5", qd[7], 9'h15A);
        chk("m_addr5", qa[7], 5);
        check_frame(0, "m");

        // reset while EN is high during a character write
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            hit = b.LCD_EN && b.LCD_RS;
        end
        chk("abort_en_high", hit, 1);
        do_reset();
        init_timeline();
        check_init_seq("reinit");
        chk("en_width", bad_en, 0);

        // 4x20 build: row bases and last address
        rst4 = 1'b0;
        b4.start = 1'b1;
        @(negedge clk);
        b4.start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk);
            hit = b4.frame_done;
        end
        chk("w_frame_done", hit, 1);
        chk("w_last_addr", b4.mem_addr, 79);
        chk("w_cmd_cnt", cq4.size(), 8);
        for (int k = 0; k < 8; k++) chk("w_cmd", cq4[k], e4[k]);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
